// File: rtl/lfsr_pkg.sv
// Shared definitions for 16-bit LFSR blocks: the next-state function and
// the state encoding used by the sequence checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // One step of the 16-bit Galois-style LFSR.
  // bit0 = s15, bit1 = s0, bit2 = s1^s15, bits3..14 = s2..s13, bit15 = s14^s15.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14] ^ s[15], s[13:2], s[1] ^ s[15], s[0], s[15]};
  endfunction

endpackage

// File: rtl/lfsr_16_checker.sv
// Tracks a received 16-bit LFSR word stream: hunts for a seed, verifies a run
// of correct successors, then free-runs (flywheels) while counting mismatches.
module lfsr_16_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] data_in,
  input  logic        err_clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_RUN = 4'(LOSS_COUNT);

  chk_state_t  state_reg;
  logic [15:0] expected_reg;
  logic [3:0]  run_reg;

  logic        word_match;
  logic        err_hit;
  logic [3:0]  run_inc;
  logic [15:0] next_of_data;
  logic [15:0] next_of_expected;

  // Per-word decode shared by the FSM and the error counter.
  always_comb begin
    word_match       = (data_in == expected_reg);
    err_hit          = valid_in && (state_reg == LOCKED) && !word_match;
    run_inc          = run_reg + 4'd1;
    next_of_data     = lfsr16_next(data_in);
    next_of_expected = lfsr16_next(expected_reg);
  end

  // Checker FSM with its registered lock indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= HUNT;
      expected_reg <= 16'h0000;
      run_reg      <= 4'd0;
      locked       <= 1'b0;
    end else if (valid_in) begin
      case (state_reg)
        HUNT: begin
          expected_reg <= next_of_data;
          run_reg      <= 4'd0;
          state_reg    <= VERIFY;
          locked       <= 1'b0;
        end
        VERIFY: begin
          // Always reseed from the received word; only a match extends the run.
          expected_reg <= next_of_data;
          if (word_match) begin
            if (run_inc == LOCK_RUN) begin
              run_reg   <= 4'd0;
              state_reg <= LOCKED;
              locked    <= 1'b1;
            end else begin
              run_reg <= run_inc;
            end
          end else begin
            run_reg <= 4'd0;
          end
        end
        LOCKED: begin
          // Flywheel: the local sequence advances regardless of the input.
          expected_reg <= next_of_expected;
          if (word_match) begin
            run_reg <= 4'd0;
          end else if (run_inc == LOSS_RUN) begin
            run_reg   <= 4'd0;
            state_reg <= HUNT;
            locked    <= 1'b0;
          end else begin
            run_reg <= run_inc;
          end
        end
        default: begin
          state_reg    <= HUNT;
          expected_reg <= 16'h0000;
          run_reg      <= 4'd0;
          locked       <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse and saturating error counter; a clear coinciding with an
  // error leaves that error counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= 16'h0000;
    end else begin
      err_pulse <= err_hit;
      if (err_clear) begin
        err_count <= err_hit ? 16'h0001 : 16'h0000;
      end else if (err_hit && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_16_checker.sv
// Scoreboard bench for lfsr_16_checker: a reference model predicts the
// registered outputs for every driven cycle; predictions are queued and
// compared one cycle later. A second instance with a long loss count runs
// the error counter into saturation.
module tb_lfsr_16_checker;

  logic        clk = 1'b0;
  logic        rst, valid_in, err_clear;
  logic [15:0] data_in;
  logic        locked, err_pulse;
  logic [15:0] err_count;

  logic        s_rst, s_valid, s_clr;
  logic [15:0] s_data;
  logic        s_locked, s_pulse;
  logic [15:0] s_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_16_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .err_clear(err_clear), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count)
  );

  lfsr_16_checker #(.LOCK_COUNT(1), .LOSS_COUNT(15)) u_sat (
    .clk(clk), .rst(s_rst), .valid_in(s_valid), .data_in(s_data),
    .err_clear(s_clr), .locked(s_locked), .err_pulse(s_pulse),
    .err_count(s_count)
  );

  typedef struct {
    logic        l;
    logic        p;
    logic [15:0] c;
  } exp_t;
  exp_t sb[$];

  // Reference model state (0=HUNT, 1=VERIFY, 2=LOCKED)
  int          m_st  = 0;
  logic [15:0] m_exp = 16'h0;
  int          m_run = 0;
  logic [15:0] m_cnt = 16'h0;
  logic        m_pulse = 1'b0;

  // Shift-and-tap form of the LFSR step.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic [15:0] r;
    r = {s[14:0], s[15]};
    if (s[15]) r = r ^ 16'h8004;
    return r;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic clr, input logic r);
    logic hit;
    if (r) begin
      m_st = 0; m_exp = 16'h0; m_run = 0; m_cnt = 16'h0; m_pulse = 1'b0;
    end else begin
      hit = v && (m_st == 2) && (d != m_exp);
      if (v) begin
        if (m_st == 0) begin
          m_exp = ref_next(d); m_run = 0; m_st = 1;
        end else if (m_st == 1) begin
          if (d == m_exp) begin
            m_run = m_run + 1;
            if (m_run == 4) begin m_st = 2; m_run = 0; end
          end else begin
            m_run = 0;
          end
          m_exp = ref_next(d);
        end else begin
          if (d == m_exp) m_run = 0;
          else begin
            m_run = m_run + 1;
            if (m_run == 3) begin m_st = 0; m_run = 0; end
          end
          m_exp = ref_next(m_exp);
        end
      end
      if (clr) m_cnt = hit ? 16'h1 : 16'h0;
      else if (hit && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      m_pulse = hit;
    end
  endtask

  // Drive one cycle on the main DUT, predict, then compare after the edge.
  task automatic drive(input logic v, input logic [15:0] d, input logic clr, input logic r);
    exp_t e;
    rst = r; valid_in = v; data_in = d; err_clear = clr;
    model_step(v, d, clr, r);
    e.l = (m_st == 2); e.p = m_pulse; e.c = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_value("locked", 32'(locked), 32'(e.l));
    check_value("err_pulse", 32'(err_pulse), 32'(e.p));
    check_value("err_count", 32'(err_count), 32'(e.c));
    $display("cyc v=%0b d=%04h clr=%0b rst=%0b -> locked=%0b pulse=%0b count=%0d",
             v, d, clr, r, locked, err_pulse, err_count);
  endtask

  task automatic good_word();
    drive(1'b1, m_exp, 1'b0, 1'b0);
  endtask

  task automatic bad_word();
    drive(1'b1, m_exp ^ 16'h1234, 1'b0, 1'b0);
  endtask

  // One word on the saturation instance.
  task automatic s_word(input logic [15:0] d);
    s_valid = 1'b1; s_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s_exp;
    int          n_err;
    rst = 1'b1; valid_in = 1'b0; data_in = 16'h0; err_clear = 1'b0;
    s_rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_clr = 1'b0;

    // Reset state
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);

    // Lock: seed + 3 matches, 4th match locks, then flywheel matches
    drive(1'b1, 16'h4000, 1'b0, 1'b0);
    drive(1'b1, 16'h8000, 1'b0, 1'b0);
    drive(1'b1, 16'h8005, 1'b0, 1'b0);
    drive(1'b1, 16'h800F, 1'b0, 1'b0);
    check_value("not_yet_locked", 32'(locked), 32'd0);
    good_word();
    check_value("locked_after_5th", 32'(locked), 32'd1);
    repeat (3) good_word();

    // Single error, flywheel keeps lock
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    check_value("single_err_pulse", 32'(err_pulse), 32'd1);
    check_value("single_err_count", 32'(err_count), 32'd1);
    repeat (3) good_word();
    check_value("still_locked", 32'(locked), 32'd1);

    // err_clear alone
    drive(1'b1, m_exp, 1'b1, 1'b0);
    check_value("clear_alone", 32'(err_count), 32'd0);

    // Loss after 3 consecutive mismatches, then reseed
    repeat (2) bad_word();
    check_value("locked_before_loss", 32'(locked), 32'd1);
    bad_word();
    check_value("loss_count", 32'(err_count), 32'd3);
    check_value("lost_lock", 32'(locked), 32'd0);
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
    drive(1'b1, 16'h0BAD, 1'b0, 1'b0);
    check_value("verify_no_err", 32'(err_count), 32'd3);

    // Reseed in VERIFY
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 16'h0003, 1'b0, 1'b0);
    check_value("reseed_no_pulse", 32'(err_pulse), 32'd0);
    check_value("reseed_expected", 32'(m_exp), 32'h0006);
    drive(1'b1, 16'h0006, 1'b0, 1'b0);
    repeat (2) good_word();
    check_value("reseed_not_locked", 32'(locked), 32'd0);
    good_word();
    check_value("reseed_locked", 32'(locked), 32'd1);

    // Gaps on alternate cycles, including a wrong word on a gap
    for (int i = 0; i < 6; i++) begin
      good_word();
      drive(1'b0, 16'hDEAD, 1'b0, 1'b0);
    end
    check_value("gap_locked", 32'(locked), 32'd1);
    check_value("gap_count", 32'(err_count), 32'd0);

    // Error alongside err_clear
    bad_word();
    bad_word();
    drive(1'b1, 16'hAAAA ^ m_exp, 1'b1, 1'b0);
    check_value("clear_with_err", 32'(err_count), 32'd1);
    good_word();

    // Reset mid-lock with competing inputs
    drive(1'b1, 16'h5555, 1'b1, 1'b1);
    check_value("rst_locked", 32'(locked), 32'd0);
    check_value("rst_count", 32'(err_count), 32'd0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Saturation on the long-loss instance: 14 errors then 1 match, repeated
    @(posedge clk); #1;
    s_rst = 1'b0;
    s_word(16'h4000);
    s_word(16'h8000);
    check_value("sat_locked", 32'(s_locked), 32'd1);
    s_exp = ref_next(16'h8000);
    n_err = 0;
    while (n_err < 65540) begin
      for (int k = 0; k < 14; k++) begin
        s_word(~s_exp);
        s_exp = ref_next(s_exp);
        n_err++;
        if (n_err == 65534)
          check_value("sat_near", 32'(s_count), 32'd65534);
      end
      s_word(s_exp);
      s_exp = ref_next(s_exp);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    check_value("sat_count", 32'(s_count), 32'hFFFF);
    check_value("sat_still_locked", 32'(s_locked), 32'd1);
    s_word(~s_exp);
    check_value("sat_hold", 32'(s_count), 32'hFFFF);
    check_value("sat_pulse", 32'(s_pulse), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_16_checker.md
LFSR_16_CHECKER -- requirements
Module: lfsr_16_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive correct predictions needed to declare lock (legal range 1..15).
REQ-002 Parameter LOSS_COUNT, default 3: consecutive mismatches in LOCKED that drop lock (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid_in  input  1  data_in carries one LFSR word this cycle.
REQ-006 data_in  input  16  received LFSR state word.
REQ-007 err_clear  input  1  synchronous clear of err_count.
REQ-008 locked  output  1  high while FSM is in LOCKED.
REQ-009 err_pulse  output  1  one-cycle pulse per mismatched word while LOCKED.
REQ-010 err_count  output  16  saturating count of mismatched words while LOCKED.

Function
REQ-011 Next-state function next(s) SHALL be: bit0=s15; bit1=s0; bit2=s1^s15; bits3..14=s2..s13; bit15=s14^s15.
REQ-012 Internal registers: expected[15:0], run counter[3:0], FSM state in {HUNT, VERIFY, LOCKED}.
REQ-013 Cycles with valid_in low SHALL leave all state, expected and counters unchanged; err_pulse low.
REQ-014 HUNT, valid word: expected <= next(data_in), run <= 0, go VERIFY.
REQ-015 VERIFY, valid word equal to expected: expected <= next(data_in), run <= run+1; if run+1 == LOCK_COUNT go LOCKED with run <= 0.
REQ-016 VERIFY, valid word not equal: expected <= next(data_in), run <= 0, stay VERIFY (reseed, no error counted).
REQ-017 LOCKED, valid word equal: expected <= next(expected), run <= 0.
REQ-018 LOCKED, valid word not equal: expected <= next(expected) (flywheel, no reseed), run <= run+1, err_pulse high next cycle, err_count increments.
REQ-019 LOCKED: if mismatch makes run == LOSS_COUNT, go HUNT, run <= 0; that mismatch still counts as an error.
REQ-020 All outputs registered: locked/err_pulse/err_count reflect a word one cycle after its valid_in cycle.
REQ-021 err_count saturates at 0xFFFF; no wrap.
REQ-022 err_clear and an error in the same cycle: err_count <= 1.
REQ-023 err_clear alone: err_count <= 0; FSM and expected unaffected.
REQ-024 Mismatches in HUNT/VERIFY never assert err_pulse nor change err_count.

Reset
REQ-025 rst high at any clock edge, including mid-lock: state <= HUNT, expected <= 0, run <= 0, locked <= 0, err_pulse <= 0, err_count <= 0.
REQ-026 rst takes priority over valid_in and err_clear in the same cycle.

Structure
REQ-027 Package lfsr_pkg SHALL hold the 16-bit next-state function of REQ-011 and the checker FSM state enum; it is the single definition shared by every 16-bit LFSR block.
REQ-028 No sub-modules; one FSM block plus registered outputs.

Verification
REQ-029 Lock: after reset, valid words 0x4000, 0x8000, 0x8005, 0x800F, then 4 correct successors -> locked rises one cycle after the 5th word (1 seed + 4 matches); err_count 0.
REQ-030 Single error: locked; send 0x1234 in place of expected word, then correct successors -> err_pulse one cycle, err_count 1, locked stays 1, next correct word matches via flywheel.
REQ-031 Loss: locked; 3 consecutive wrong words -> err_count 3, locked falls one cycle after 3rd; next valid word reseeds (HUNT->VERIFY).
REQ-032 Reseed in VERIFY: seed 0x0001, send 0x0003 (expected 0x0002) -> no err_pulse, next expected = next(0x0003) = 0x0006; lock after 4 further matches.
REQ-033 Gaps/clear: locked stream with valid_in low on alternate cycles -> no state change on gaps; err_clear with an error -> err_count 1; rst mid-lock -> all outputs 0 next cycle.
REQ-034 Saturation: force 65,540 errors under repeated re-lock (or reduced-width bench override) -> err_count holds 0xFFFF.
